// File: rtl/clk_seq_pkg.sv
// Shared types and defaults for the clock/power sequencer.
// State encoding is fixed because STATE is exported for debug.
package clk_seq_pkg;

    typedef enum logic [2:0] {
        CS_HOLD = 3'd0,
        CS_RUN  = 3'd1,
        CS_HALT = 3'd2,
        CS_GATE = 3'd3,
        CS_OFF  = 3'd4,
        CS_STAB = 3'd5
    } cs_state_e;

    localparam int CS_STAB_CYCLES_DEF = 64;
    localparam int CS_GATE_CYCLES_DEF = 2;

    typedef struct packed {
        logic osc_ena;
        logic clk_ena;
        logic osc_stable;
    } cs_out_t;

    function automatic cs_out_t cs_decode(input cs_state_e s);
        cs_out_t o;
        case (s)
            CS_HOLD: o = '{osc_ena: 1'b1, clk_ena: 1'b0, osc_stable: 1'b0};
            CS_RUN:  o = '{osc_ena: 1'b1, clk_ena: 1'b1, osc_stable: 1'b1};
            CS_HALT: o = '{osc_ena: 1'b1, clk_ena: 1'b0, osc_stable: 1'b1};
            CS_GATE: o = '{osc_ena: 1'b1, clk_ena: 1'b0, osc_stable: 1'b0};
            CS_OFF:  o = '{osc_ena: 1'b0, clk_ena: 1'b0, osc_stable: 1'b0};
            CS_STAB: o = '{osc_ena: 1'b1, clk_ena: 1'b0, osc_stable: 1'b0};
            default: o = '{osc_ena: 1'b1, clk_ena: 1'b0, osc_stable: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/clk_power_seq_if.sv
// Signal bundle between decoder/interrupt logic, the sequencer and the clock block.
// No valid/ready here: requests are levels qualified only by the one-cycle T4_STB pulse,
// and WAKE is a plain level; outputs are registered levels.
interface clk_power_seq_if;
    logic       T4_STB;
    logic       HALT_REQ;
    logic       STOP_REQ;
    logic       WAKE;
    logic       OSC_ENA;
    logic       CLK_ENA;
    logic       OSC_STABLE;
    logic [2:0] STATE;

    modport master (
        output T4_STB, HALT_REQ, STOP_REQ, WAKE,
        input  OSC_ENA, CLK_ENA, OSC_STABLE, STATE
    );

    modport slave (
        input  T4_STB, HALT_REQ, STOP_REQ, WAKE,
        output OSC_ENA, CLK_ENA, OSC_STABLE, STATE
    );
endinterface

// File: rtl/clk_power_seq_sat_down_cnt.sv
// Loadable down-counter that sticks at zero; reset loads RST_VAL.
module sat_down_cnt #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_power_seq.sv
// Power-state sequencer driving OSC_ENA/CLK_ENA; CPU clock changes only after a T4 strobe
// so a machine cycle is never cut short (RESET excepted).
module clk_power_seq
    import clk_seq_pkg::*;
#(
    parameter int STAB_CYCLES = CS_STAB_CYCLES_DEF,
    parameter int GATE_CYCLES = CS_GATE_CYCLES_DEF
) (
    input logic             CLK,
    input logic             RESET,
    clk_power_seq_if.slave  bus
);

    localparam int CNT_MAX = (STAB_CYCLES > GATE_CYCLES) ? STAB_CYCLES : GATE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] STAB_LD = CW'(STAB_CYCLES);
    localparam logic [CW-1:0] GATE_LD = CW'(GATE_CYCLES);

    cs_state_e     state_q;
    cs_state_e     state_d;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_ld_val;
    logic [CW-1:0] cnt;
    logic          cnt_zero;
    cs_out_t       outs;

    sat_down_cnt #(
        .W       (CW),
        .RST_VAL (STAB_LD)
    ) u_cnt (
        .clk      (CLK),
        .rst      (RESET),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= CS_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = STAB_LD;
        case (state_q)
            CS_HOLD, CS_STAB: begin
                cnt_dec = 1'b1;
                if (cnt_zero && bus.T4_STB) state_d = CS_RUN;
            end
            CS_RUN: begin
                if (bus.T4_STB) begin
                    if (bus.STOP_REQ) begin
                        state_d    = CS_GATE;
                        cnt_load   = 1'b1;
                        cnt_ld_val = GATE_LD;
                    end else if (bus.HALT_REQ && !bus.WAKE) begin
                        state_d = CS_HALT;
                    end
                end
            end
            CS_HALT: begin
                if (bus.WAKE && bus.T4_STB) state_d = CS_RUN;
            end
            CS_GATE: begin
                // Leave as the count reaches zero so GATE lasts exactly GATE_CYCLES cycles.
                cnt_dec = 1'b1;
                if (cnt <= CW'(1)) state_d = CS_OFF;
            end
            CS_OFF: begin
                if (bus.WAKE) begin
                    state_d    = CS_STAB;
                    cnt_load   = 1'b1;
                    cnt_ld_val = STAB_LD;
                end
            end
            default: state_d = CS_HOLD;
        endcase
    end

    always_comb begin
        outs = cs_decode(state_q);
    end

    assign bus.OSC_ENA    = outs.osc_ena;
    assign bus.CLK_ENA    = outs.clk_ena;
    assign bus.OSC_STABLE = outs.osc_stable;
    assign bus.STATE      = state_q;

endmodule

// File: tb/tb_clk_power_seq.sv
// Bench for clk_power_seq: STAB=8, GATE=2, T4_STB on every 4th cycle.
module tb_clk_power_seq;

  localparam int STAB = 8;
  localparam int GATE = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  clk_power_seq_if sif();

  clk_power_seq #(
    .STAB_CYCLES (STAB),
    .GATE_CYCLES (GATE)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (sif.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic       halt;
    logic       stop;
    logic       wake;
    logic       strobe;
    logic [2:0] exp_state;
    string      name;
  } vec_t;

  vec_t vecs[9];

  // expected {STATE, OSC_ENA, CLK_ENA, OSC_STABLE} for a state
  function automatic logic [5:0] exp_vec(input logic [2:0] s);
    case (s)
      3'd0: return {s, 3'b100};
      3'd1: return {s, 3'b111};
      3'd2: return {s, 3'b101};
      3'd3: return {s, 3'b100};
      3'd4: return {s, 3'b000};
      3'd5: return {s, 3'b100};
      default: return {s, 3'b000};
    endcase
  endfunction

  function automatic logic [5:0] act_vec();
    return {sif.STATE, sif.OSC_ENA, sif.CLK_ENA, sif.OSC_STABLE};
  endfunction

  task automatic step();
    @(posedge CLK);
    cyc++;
    #1;
    sif.T4_STB = ((cyc % 4) == 3);
  endtask

  task automatic chk_q(input string name);
    logic [5:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", name, act_vec());
      return;
    end
    e = exp_q.pop_front();
    if (act_vec() !== e) begin
      bad++;
      $display("FAIL %s: cyc=%0d got {state,osc,clk,stable}=%b want %b", name, cyc, act_vec(), e);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step_exp(input logic [2:0] s, input string name);
    exp_q.push_back(exp_vec(s));
    step();
    chk_q(name);
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 8 && !sif.T4_STB; i++) step();
  endtask

  // r = edge that loaded the stabilisation count; CLK_ENA must rise on the
  // first strobe-qualified edge at least STAB+1 edges later.
  task automatic wait_run(input int r, input logic [2:0] hold_s, input string name);
    int e_exp;
    int rise;
    int ok;
    e_exp = r + STAB + 1;
    while (((e_exp - 1) % 4) != 3) e_exp++;
    rise = -1;
    ok = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sif.OSC_ENA !== 1'b1) ok = 0;
      if (sif.CLK_ENA === 1'b1) begin
        rise = cyc;
        break;
      end
      if (sif.STATE !== hold_s) ok = 0;
    end
    chk_int({name, " osc/state while waiting"}, ok, 1);
    chk_int({name, " clk_ena rise edge"}, rise, e_exp);
    chk_int({name, " state after rise"}, int'(sif.STATE), 1);
  endtask

  task automatic recover(input string name);
    sif.HALT_REQ = 1'b0;
    sif.STOP_REQ = 1'b0;
    sif.WAKE = 1'b1;
    for (int i = 0; i < 60 && sif.STATE !== 3'd1; i++) step();
    chk_int({name, " recover to run"}, int'(sif.STATE), 1);
    sif.WAKE = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    logic prev_t4;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, "run idle"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, "halt req"};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, "halt bypass"};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd3, "stop req"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, "stop over halt"};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd3, "stop with wake"};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd3, "all req"};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, "wake only"};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "req without strobe"};

    sif.T4_STB = 1'b0;
    sif.HALT_REQ = 1'b0;
    sif.STOP_REQ = 1'b0;
    sif.WAKE = 1'b0;

    // power-on reset and hold
    RESET = 1'b1;
    step();
    step();
    step_exp(3'd0, "reset state");
    r = cyc;
    RESET = 1'b0;
    wait_run(r, 3'd0, "por");

    // decisions taken from RUN
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      if (v.strobe) wait_strobe();
      else if (sif.T4_STB) step();
      sif.HALT_REQ = v.halt;
      sif.STOP_REQ = v.stop;
      sif.WAKE = v.wake;
      step_exp(v.exp_state, v.name);
      recover(v.name);
    end

    // HALT, WAKE raised between strobes
    wait_strobe();
    sif.HALT_REQ = 1'b1;
    step_exp(3'd2, "halt enter");
    sif.HALT_REQ = 1'b0;
    step_exp(3'd2, "halt hold");
    if (sif.T4_STB) step_exp(3'd2, "halt hold2");
    sif.WAKE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prev_t4 = sif.T4_STB;
      step_exp(prev_t4 ? 3'd1 : 3'd2, "halt wake");
      if (prev_t4) break;
    end
    sif.WAKE = 1'b0;

    // STOP full cycle
    wait_strobe();
    sif.STOP_REQ = 1'b1;
    step_exp(3'd3, "stop gate1");
    sif.STOP_REQ = 1'b0;
    step_exp(3'd3, "stop gate2");
    step_exp(3'd4, "stop off");
    for (int i = 0; i < 19; i++) step_exp(3'd4, "stop off hold");
    sif.WAKE = 1'b1;
    step_exp(3'd5, "stop wake osc");
    r = cyc;
    sif.WAKE = 1'b0;
    wait_run(r, 3'd5, "stop stab");

    // STOP with WAKE high throughout
    sif.WAKE = 1'b1;
    wait_strobe();
    sif.STOP_REQ = 1'b1;
    step_exp(3'd3, "wake-high gate1");
    sif.STOP_REQ = 1'b0;
    step_exp(3'd3, "wake ignored in gate");
    step_exp(3'd4, "off one cycle");
    step_exp(3'd5, "stab after one off");
    r = cyc;
    wait_run(r, 3'd5, "wake-high stab");
    sif.WAKE = 1'b0;

    // RESET in STAB with cnt=3
    wait_strobe();
    sif.STOP_REQ = 1'b1;
    step_exp(3'd3, "rst-stab gate1");
    sif.STOP_REQ = 1'b0;
    step_exp(3'd3, "rst-stab gate2");
    step_exp(3'd4, "rst-stab off");
    sif.WAKE = 1'b1;
    step_exp(3'd5, "rst-stab enter");
    sif.WAKE = 1'b0;
    for (int i = 0; i < 5; i++) step_exp(3'd5, "rst-stab count");
    RESET = 1'b1;
    step_exp(3'd0, "reset in stab");
    r = cyc;
    RESET = 1'b0;
    wait_run(r, 3'd0, "rst-stab hold");

    // RESET in GATE
    wait_strobe();
    sif.STOP_REQ = 1'b1;
    step_exp(3'd3, "rst-gate gate1");
    sif.STOP_REQ = 1'b0;
    RESET = 1'b1;
    step_exp(3'd0, "reset in gate");
    r = cyc;
    RESET = 1'b0;
    wait_run(r, 3'd0, "rst-gate hold");

    chk_int("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
